sync_floating_collisions: RTL and testbench

//  Frogger playfield core. Recovers VGA column/row counters from incoming

---
 rtl/sync_floating_collisions_pkg.sv | 27 ++
 rtl/sync_floating_collisions_if.sv | 39 +++
 rtl/sync_floating_collisions_sync_counter.sv | 68 ++++++
 rtl/sync_floating_collisions.sv | 132 +++++++++++++
 tb/tb_sync_floating_collisions.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sync_floating_collisions_pkg.sv
// Shared constants and types for the Frogger playfield core.
// Tile coordinates are 6 bits wide; one tile is 32 pixels.
package sync_floating_collisions_pkg;

   localparam int TILE_SIZE   = 32;
   localparam int GAME_WIDTH  = 14;
   localparam int GAME_HEIGHT = 13;
   localparam int NUM_LOGS    = 5;
   localparam int NUM_CARS    = 5;
   localparam int TILE_W      = 6;
   localparam int COUNT_W     = 10;
   localparam int TIMER_W     = 23;

   typedef logic [TILE_W-1:0]  tile_t;
   typedef logic [COUNT_W-1:0] count_t;

   typedef struct packed {
      tile_t x;
      tile_t y;
   } tile_pos_t;

   // Exact 6-bit match of two tile positions.
   function automatic logic tile_match(tile_pos_t a, tile_pos_t b);
      return (a.x == b.x) && (a.y == b.y);
   endfunction

endpackage

// File: rtl/sync_floating_collisions_if.sv
// Playfield bus between the sync generator / frog control side (master)
// and the playfield core (slave). Array element n-1 corresponds to car/log n.
interface sync_floating_collisions_if;
   import sync_floating_collisions_pkg::*;

   logic                     i_HSync;
   logic                     i_VSync;
   tile_t                    i_Frogger_X;
   tile_t                    i_Frogger_Y;
   tile_t                    i_Frogger_Orig_X;
   tile_t                    i_Frogger_Orig_Y;
   tile_t [NUM_CARS-1:0]     i_Car_X;
   tile_t [NUM_CARS-1:0]     i_Car_Y;

   logic                     o_HSync;
   logic                     o_VSync;
   count_t                   o_Col_Count;
   count_t                   o_Row_Count;
   tile_t [NUM_LOGS-1:0]     o_Floating_X;
   tile_t [NUM_LOGS-1:0]     o_Floating_Y;
   logic                     o_Collided;

   modport slave (
      input  i_HSync, i_VSync,
      input  i_Frogger_X, i_Frogger_Y, i_Frogger_Orig_X, i_Frogger_Orig_Y,
      input  i_Car_X, i_Car_Y,
      output o_HSync, o_VSync, o_Col_Count, o_Row_Count,
      output o_Floating_X, o_Floating_Y, o_Collided
   );

   modport master (
      output i_HSync, i_VSync,
      output i_Frogger_X, i_Frogger_Y, i_Frogger_Orig_X, i_Frogger_Orig_Y,
      output i_Car_X, i_Car_Y,
      input  o_HSync, o_VSync, o_Col_Count, o_Row_Count,
      input  o_Floating_X, o_Floating_Y, o_Collided
   );

endinterface

// File: rtl/sync_floating_collisions_sync_counter.sv
// Recovers pixel column/row counters from incoming sync.
// A VSync rising edge realigns both counters to zero and takes priority
// over the normal column/row wrap.
module sync_counter
   import sync_floating_collisions_pkg::*;
#(
   parameter int TOTAL_COLS = 800,
   parameter int TOTAL_ROWS = 525
) (
   input  logic   i_Clk,
   input  logic   i_Reset,
   input  logic   i_HSync,
   input  logic   i_VSync,
   output logic   o_HSync,
   output logic   o_VSync,
   output count_t o_Col_Count,
   output count_t o_Row_Count
);

   logic   hsync_q;
   logic   vsync_q;
   count_t col_q, col_d;
   count_t row_q, row_d;
   logic   vsync_rise;

   // Registered VSync doubles as the previous-sample for edge detection.
   assign vsync_rise = i_VSync & ~vsync_q;

   // Next column/row: realign on VSync edge, else advance with wrap.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (vsync_rise) begin
         col_d = '0;
         row_d = '0;
      end else if (col_q == count_t'(TOTAL_COLS - 1)) begin
         col_d = '0;
         if (row_q == count_t'(TOTAL_ROWS - 1)) begin
            row_d = '0;
         end else begin
            row_d = row_q + count_t'(1);
         end
      end else begin
         col_d = col_q + count_t'(1);
      end
   end

   // Sync delay and counter state.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         hsync_q <= i_HSync;
         vsync_q <= i_VSync;
         col_q   <= col_d;
         row_q   <= row_d;
      end
   end

   assign o_HSync     = hsync_q;
   assign o_VSync     = vsync_q;
   assign o_Col_Count = col_q;
   assign o_Row_Count = row_q;

endmodule

// File: rtl/sync_floating_collisions.sv
// Frogger playfield core: sync-derived pixel counters, five river logs
// stepping left on a shared timer, and a registered frog/hazard collision flag.
// Optional build macro WATER_DROWN_EN: frog on a water lane (rows 1..5) but
// not on that lane's log also counts as a hit. Without it only cars collide.
module sync_floating_collisions
   import sync_floating_collisions_pkg::*;
#(
   parameter int TOTAL_COLS = 800,
   parameter int TOTAL_ROWS = 525,
   parameter int SLOW_COUNT = 4200000,
   parameter int LOG_INIT_X = 13,
   parameter int LOG_MIN_X  = 0,
   parameter int LOG_SPEED  = 1
) (
   input  logic                        i_Clk,
   input  logic                        i_Reset,
   sync_floating_collisions_if.slave   bus
);

   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 log_step;
   tile_t [NUM_LOGS-1:0] log_x;
   logic [NUM_CARS-1:0]  car_hit;
   logic [NUM_LOGS-1:0]  water_hit;
   logic                 at_spawn;
   logic                 hit_d;
   logic                 collided_q;
   tile_pos_t            frog_pos;

   sync_counter #(
      .TOTAL_COLS (TOTAL_COLS),
      .TOTAL_ROWS (TOTAL_ROWS)
   ) u_sync_counter (
      .i_Clk       (i_Clk),
      .i_Reset     (i_Reset),
      .i_HSync     (bus.i_HSync),
      .i_VSync     (bus.i_VSync),
      .o_HSync     (bus.o_HSync),
      .o_VSync     (bus.o_VSync),
      .o_Col_Count (bus.o_Col_Count),
      .o_Row_Count (bus.o_Row_Count)
   );

   assign log_step = (timer_q == TIMER_W'(SLOW_COUNT - 1));

   // Shared step timer: counts 0..SLOW_COUNT-1, restarts on terminal count.
   always_comb begin
      timer_d = timer_q + TIMER_W'(1);
      if (log_step) begin
         timer_d = '0;
      end
   end

   // Step timer register.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   for (genvar g = 0; g < NUM_LOGS; g++) begin : g_log
      tile_t x_q, x_d;

      // Step left; a log that cannot move a full step wraps back to the start.
      always_comb begin
         x_d = x_q;
         if (log_step) begin
            if (x_q < tile_t'(LOG_MIN_X + LOG_SPEED)) begin
               x_d = tile_t'(LOG_INIT_X);
            end else begin
               x_d = x_q - tile_t'(LOG_SPEED);
            end
         end
      end

      // Log column register.
      always_ff @(posedge i_Clk or posedge i_Reset) begin
         if (i_Reset) begin
            x_q <= tile_t'(LOG_INIT_X);
         end else begin
            x_q <= x_d;
         end
      end

      assign log_x[g]     = x_q;
      assign water_hit[g] = (bus.i_Frogger_Y == tile_t'(g + 1)) && (bus.i_Frogger_X != x_q);
   end

   assign bus.o_Floating_X = log_x;

   for (genvar g = 0; g < NUM_LOGS; g++) begin : g_lane_y
      assign bus.o_Floating_Y[g] = tile_t'(g + 1);
   end

   assign frog_pos = '{x: bus.i_Frogger_X, y: bus.i_Frogger_Y};

   for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
      assign car_hit[g] = tile_match(frog_pos, '{x: bus.i_Car_X[g], y: bus.i_Car_Y[g]});
   end

   assign at_spawn = tile_match(frog_pos, '{x: bus.i_Frogger_Orig_X, y: bus.i_Frogger_Orig_Y});

   // Combined hazard hit; the spawn tile is always safe.
   always_comb begin
      hit_d = |car_hit;
`ifdef WATER_DROWN_EN
      hit_d = hit_d | (|water_hit);
`endif
      if (at_spawn) begin
         hit_d = 1'b0;
      end
   end

   // Collision flag follows the hit level with one clock of latency.
   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         collided_q <= 1'b0;
      end else begin
         collided_q <= hit_d;
      end
   end

   assign bus.o_Collided = collided_q;

`ifndef WATER_DROWN_EN
   logic unused_water;
   assign unused_water = |water_hit;
`endif

endmodule

// File: tb/tb_sync_floating_collisions.sv
module tb_sync_floating_collisions;
   import sync_floating_collisions_pkg::*;

   localparam int ROWS = 20;

   localparam int SIG_COL  = 0;
   localparam int SIG_ROW  = 1;
   localparam int SIG_HS   = 2;
   localparam int SIG_VS   = 3;
   localparam int SIG_COLL = 4;
   localparam int SIG_FX   = 5;   // 5..9  : log 1..5 X
   localparam int SIG_FY   = 10;  // 10..14: log 1..5 Y

   typedef struct {
      int unsigned cyc;
      int          sig;
      int          val;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   exp_t        sb_q[$];

   sync_floating_collisions_if bus();

   sync_floating_collisions #(
      .TOTAL_COLS (800),
      .TOTAL_ROWS (ROWS),
      .SLOW_COUNT (4),
      .LOG_INIT_X (13),
      .LOG_MIN_X  (0),
      .LOG_SPEED  (1)
   ) dut (
      .i_Clk   (clk),
      .i_Reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int actual(int sig);
      case (sig)
         SIG_COL:  return int'(bus.o_Col_Count);
         SIG_ROW:  return int'(bus.o_Row_Count);
         SIG_HS:   return int'(bus.o_HSync);
         SIG_VS:   return int'(bus.o_VSync);
         SIG_COLL: return int'(bus.o_Collided);
         default: begin
            if (sig >= SIG_FY) return int'(bus.o_Floating_Y[sig - SIG_FY]);
            return int'(bus.o_Floating_X[sig - SIG_FX]);
         end
      endcase
   endfunction

   // Monitor: pop every expectation due this cycle and compare.
   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc <= cyc) begin
            int a;
            a = actual(sb_q[i].sig);
            n_cmp++;
            if (sb_q[i].cyc < cyc || a != sb_q[i].val) begin
               n_bad++;
               $display("FAIL %s @cyc %0d: got %0d, want %0d", sb_q[i].name, cyc, a, sb_q[i].val);
            end
            sb_q.delete(i);
         end
      end
   end

   task automatic push_exp(int sig, int val, int lat, string name);
      exp_t e;
      e.cyc  = cyc + lat;
      e.sig  = sig;
      e.val  = val;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_frog(int x, int y);
      bus.i_Frogger_X = 6'(x);
      bus.i_Frogger_Y = 6'(y);
   endtask

   task automatic set_car(int n, int x, int y);
      bus.i_Car_X[n-1] = 6'(x);
      bus.i_Car_Y[n-1] = 6'(y);
   endtask

   task automatic drain(string name);
      for (int i = 0; i < 20000 && sb_q.size() > 0; i++) step(1);
      if (sb_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: %0d checks still pending, want 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      bus.i_HSync          = 1'b0;
      bus.i_VSync          = 1'b0;
      bus.i_Frogger_Orig_X = 6'd10;
      bus.i_Frogger_Orig_Y = 6'd14;
      set_frog(10, 14);
      for (int n = 1; n <= NUM_CARS; n++) set_car(n, 20 + n, 20);

      // Reset values.
      step(2);
      push_exp(SIG_COL, 0, 1, "rst_col");
      push_exp(SIG_ROW, 0, 1, "rst_row");
      push_exp(SIG_HS, 0, 1, "rst_hs");
      push_exp(SIG_VS, 0, 1, "rst_vs");
      push_exp(SIG_COLL, 0, 1, "rst_coll");
      for (int n = 0; n < NUM_LOGS; n++) begin
         push_exp(SIG_FX + n, 13, 1, "rst_log_x");
         push_exp(SIG_FY + n, n + 1, 1, "log_y_const");
      end
      step(2);
      rst = 1'b0;

      // Log stepping: 13 for 3 clocks, 12 at 4, 0 at 52, back to 13 at 56.
      push_exp(SIG_FX + 0, 13, 3, "log1_hold");
      for (int n = 0; n < NUM_LOGS; n++) push_exp(SIG_FX + n, 12, 4, "log_first_step");
      push_exp(SIG_FX + 1, 0, 52, "log2_at_min");
      push_exp(SIG_FX + 2, 0, 55, "log3_min_hold");
      push_exp(SIG_FX + 0, 13, 56, "log1_wrap");
      push_exp(SIG_FX + 4, 12, 60, "log5_after_wrap");
      push_exp(SIG_COL, 5, 5, "free_run_col");
      push_exp(SIG_ROW, 0, 5, "free_run_row");
      step(10);

      // VSync realignment, line wrap, frame wrap.
      bus.i_VSync = 1'b1;
      bus.i_HSync = 1'b1;
      push_exp(SIG_COL, 0, 1, "vs_align_col");
      push_exp(SIG_ROW, 0, 1, "vs_align_row");
      push_exp(SIG_VS, 1, 1, "vs_delay");
      push_exp(SIG_HS, 1, 1, "hs_delay");
      push_exp(SIG_COL, 799, 800, "line_end_col");
      push_exp(SIG_ROW, 0, 800, "line_end_row");
      push_exp(SIG_COL, 0, 801, "line_wrap_col");
      push_exp(SIG_ROW, 1, 801, "line_wrap_row");
      push_exp(SIG_COL, 799, ROWS * 800, "frame_end_col");
      push_exp(SIG_ROW, ROWS - 1, ROWS * 800, "frame_end_row");
      push_exp(SIG_COL, 0, ROWS * 800 + 1, "frame_wrap_col");
      push_exp(SIG_ROW, 0, ROWS * 800 + 1, "frame_wrap_row");
      step(1);
      bus.i_HSync = 1'b0;
      push_exp(SIG_HS, 0, 1, "hs_fall");
      step(1);

      // Collisions.
      set_frog(3, 9); set_car(3, 3, 9);
      push_exp(SIG_COLL, 1, 1, "hit_car3");
      step(1);
      push_exp(SIG_COLL, 1, 1, "hit_level");
      step(1);
      set_frog(4, 9);
      push_exp(SIG_COLL, 0, 1, "leave_hazard");
      step(1);
      set_frog(3, 10);
      push_exp(SIG_COLL, 0, 1, "y_miss");
      step(1);
      set_frog(10, 14); set_car(1, 10, 14);
      push_exp(SIG_COLL, 0, 1, "spawn_safe");
      step(1);
      push_exp(SIG_COLL, 0, 1, "spawn_hold");
      step(1);
      set_frog(7, 8); set_car(5, 7, 8);
      push_exp(SIG_COLL, 1, 1, "hit_car5");
      step(1);
      set_frog(63, 63); set_car(2, 63, 63);
      push_exp(SIG_COLL, 1, 1, "hit_max_tile");
      step(1);
      set_frog(62, 63);
      push_exp(SIG_COLL, 0, 1, "x_miss");
      step(1);
      set_frog(63, 2);
`ifdef WATER_DROWN_EN
      push_exp(SIG_COLL, 1, 1, "water_row");
`else
      push_exp(SIG_COLL, 0, 1, "water_row");
`endif
      step(1);
      set_frog(10, 14);
      push_exp(SIG_COLL, 0, 1, "back_to_spawn");
      step(1);
      drain("frame_drain");

      // Mid-frame reset with a live hit, then realign.
      bus.i_VSync = 1'b0;
      set_frog(3, 9);
      step(2);
      rst = 1'b1;
      push_exp(SIG_COL, 0, 1, "mid_rst_col");
      push_exp(SIG_ROW, 0, 1, "mid_rst_row");
      push_exp(SIG_COLL, 0, 1, "mid_rst_coll");
      push_exp(SIG_FX + 2, 13, 1, "mid_rst_log");
      step(2);
      rst = 1'b0;
      push_exp(SIG_COLL, 1, 1, "post_rst_hit");
      push_exp(SIG_COL, 3, 3, "post_rst_col");
      push_exp(SIG_FX + 2, 12, 4, "post_rst_log");
      step(5);
      bus.i_VSync = 1'b1;
      push_exp(SIG_COL, 0, 1, "post_rst_align_col");
      push_exp(SIG_ROW, 0, 1, "post_rst_align_row");
      push_exp(SIG_COL, 2, 3, "post_rst_count");
      step(1);
      drain("final_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
